// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the processor
// load/store path (master 0) and the debug/DMA loader (master 1).
module dmem_arbiter #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

  state_e     state_q, state_d;
  logic       last_q, last_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rv_q, rv_d;
  logic       owner_q, owner_d;
  logic       acc0, acc1;
  logic       at_limit;

  assign acc0     = (state_q == GRANT0) & m0_req;
  assign acc1     = (state_q == GRANT1) & m1_req;
  assign at_limit = (cnt_q + 4'd1) == BURST_LIM;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      rv_q    <= 1'b0;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (m0_req && m1_req) state_d = last_q ? GRANT0 : GRANT1;
        else if (m0_req)      state_d = GRANT0;
        else if (m1_req)      state_d = GRANT1;
      end
      GRANT0: begin
        if (!m0_req)                 state_d = m1_req ? GRANT1 : IDLE;
        else if (m1_req && at_limit) state_d = GRANT1;
      end
      GRANT1: begin
        if (!m1_req)                 state_d = m0_req ? GRANT0 : IDLE;
        else if (m0_req && at_limit) state_d = GRANT0;
      end
      default: state_d = IDLE;
    endcase

    last_d = last_q;
    if (state_d == GRANT0)      last_d = 1'b0;
    else if (state_d == GRANT1) last_d = 1'b1;

    cnt_d = cnt_q;
    if (state_d != state_q)  cnt_d = '0;
    else if (acc0 || acc1)   cnt_d = cnt_q + 4'd1;

    m0_gnt    = (state_q == GRANT0);
    m1_gnt    = (state_q == GRANT1);
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (acc0) begin
      mem_rd    = ~m0_wr;
      mem_wr    = m0_wr;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (acc1) begin
      mem_rd    = ~m1_wr;
      mem_wr    = m1_wr;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end

    // Owner is captured with the read so a grant switch cannot misroute the return.
    rv_d    = mem_rd;
    owner_d = acc1;

    m0_rvalid = rv_q & ~owner_q;
    m1_rvalid = rv_q & owner_q;
    m0_rdata  = m0_rvalid ? mem_rdata : '0;
    m1_rdata  = m1_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter against a behavioural arbitration
// and memory model.
module tb_dmem_arbiter;

  localparam int MAX_BURST = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m0_req = 1'b0, m0_wr = 1'b0, m1_req = 1'b0, m1_wr = 1'b0;
  logic [7:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic       m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [7:0] m0_rdata, m1_rdata;
  logic [7:0] mem_addr, mem_wdata;
  logic       mem_rd, mem_wr;
  logic [7:0] mem_rdata = '0;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(rst_n),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       g0, g1, rd, wr;
    logic [7:0] addr, wdata;
    logic       rv0, rv1;
    logic [7:0] rd0, rd1;
  } exp_t;

  exp_t expq[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Memory device: 1-cycle read latency, garbage on the bus when not reading.
  logic [7:0] devmem [256];
  logic [7:0] refmem [256];
  always @(posedge clk) begin
    if (mem_wr) devmem[mem_addr] <= mem_wdata;
    mem_rdata <= mem_rd ? devmem[mem_addr] : 8'($urandom);
  end

  task automatic chk(input string name, input int act, input int req);
    if (act != req) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  always begin
    exp_t e;
    @(negedge clk);
    #4;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      vectors++;
      chk("m0_gnt",    int'(m0_gnt),    int'(e.g0));
      chk("m1_gnt",    int'(m1_gnt),    int'(e.g1));
      chk("mem_rd",    int'(mem_rd),    int'(e.rd));
      chk("mem_wr",    int'(mem_wr),    int'(e.wr));
      chk("mem_addr",  int'(mem_addr),  int'(e.addr));
      chk("mem_wdata", int'(mem_wdata), int'(e.wdata));
      chk("m0_rvalid", int'(m0_rvalid), int'(e.rv0));
      chk("m1_rvalid", int'(m1_rvalid), int'(e.rv1));
      chk("m0_rdata",  int'(m0_rdata),  int'(e.rd0));
      chk("m1_rdata",  int'(m1_rdata),  int'(e.rd1));
    end
  end

  // Reference model state: owner -1 means nobody holds the memory.
  int         owner = -1;
  int         last = 1;
  int         count = 0;
  bit         pend_v = 0;
  int         pend_m = 0;
  logic [7:0] pend_d = '0;

  bit         pending [2];
  bit         t_wr    [2];
  logic [7:0] t_addr  [2];
  logic [7:0] t_wdata [2];
  bit         acc_prev [2];

  task automatic cycle(input int p_req0, input int p_req1, input int p_wr, input bit rst);
    exp_t e;
    int   p_req [2];
    bit   req [2];
    int   acc_m;
    int   new_owner;
    @(negedge clk);
    #1;
    p_req[0] = p_req0;
    p_req[1] = p_req1;
    for (int m = 0; m < 2; m++) begin
      if (acc_prev[m]) pending[m] = 0;
      if (!pending[m] && int'($urandom_range(99)) < p_req[m]) begin
        pending[m] = 1;
        t_wr[m]    = int'($urandom_range(99)) < p_wr;
        t_addr[m]  = 8'($urandom);
        t_wdata[m] = 8'($urandom);
      end
      req[m] = pending[m];
    end
    rst_n    = ~rst;
    m0_req   = req[0];
    m0_wr    = req[0] ? t_wr[0]    : 1'($urandom);
    m0_addr  = req[0] ? t_addr[0]  : 8'($urandom);
    m0_wdata = req[0] ? t_wdata[0] : 8'($urandom);
    m1_req   = req[1];
    m1_wr    = req[1] ? t_wr[1]    : 1'($urandom);
    m1_addr  = req[1] ? t_addr[1]  : 8'($urandom);
    m1_wdata = req[1] ? t_wdata[1] : 8'($urandom);

    e = '0;
    acc_prev[0] = 0;
    acc_prev[1] = 0;
    if (rst) begin
      owner  = -1;
      last   = 1;
      count  = 0;
      pend_v = 0;
      expq.push_back(e);
      return;
    end

    e.g0 = (owner == 0);
    e.g1 = (owner == 1);
    if (pend_v) begin
      if (pend_m == 0) begin e.rv0 = 1; e.rd0 = pend_d; end
      else             begin e.rv1 = 1; e.rd1 = pend_d; end
    end
    acc_m  = (owner >= 0 && req[owner]) ? owner : -1;
    pend_v = 0;
    if (acc_m >= 0) begin
      acc_prev[acc_m] = 1;
      e.rd    = !t_wr[acc_m];
      e.wr    = t_wr[acc_m];
      e.addr  = t_addr[acc_m];
      e.wdata = t_wdata[acc_m];
      if (t_wr[acc_m]) refmem[t_addr[acc_m]] = t_wdata[acc_m];
      else begin
        pend_v = 1;
        pend_m = acc_m;
        pend_d = refmem[t_addr[acc_m]];
      end
    end
    expq.push_back(e);

    new_owner = owner;
    if (owner < 0) begin
      if (req[0] && req[1]) new_owner = 1 - last;
      else if (req[0])      new_owner = 0;
      else if (req[1])      new_owner = 1;
    end else if (!req[owner]) begin
      new_owner = req[1 - owner] ? 1 - owner : -1;
    end else begin
      count = (count + 1) % 16;
      if (req[1 - owner] && count == MAX_BURST) new_owner = 1 - owner;
    end
    if (new_owner != owner) count = 0;
    if (new_owner >= 0) last = new_owner;
    owner = new_owner;
  endtask

  typedef struct {
    int p0, p1, pwr, prst, n;
  } phase_t;

  phase_t phases [6];
  int     rst_left = 0;

  initial begin
    for (int unsigned i = 0; i < 256; i++) begin
      devmem[i] = 8'($urandom);
      refmem[i] = devmem[i];
    end
    for (int m = 0; m < 2; m++) begin
      pending[m]  = 0;
      acc_prev[m] = 0;
    end
    phases[0] = '{p0: 0,   p1: 100, pwr: 0,   prst: 0, n: 200};
    phases[1] = '{p0: 100, p1: 0,   pwr: 100, prst: 0, n: 200};
    phases[2] = '{p0: 100, p1: 100, pwr: 50,  prst: 0, n: 400};
    phases[3] = '{p0: 60,  p1: 60,  pwr: 40,  prst: 2, n: 800};
    phases[4] = '{p0: 20,  p1: 90,  pwr: 30,  prst: 1, n: 600};
    phases[5] = '{p0: 100, p1: 100, pwr: 20,  prst: 3, n: 800};

    // Reset held with both masters requesting, then released on a tie.
    for (int i = 0; i < 4; i++) cycle(100, 100, 0, 1'b1);
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < phases[ph].n; i++) begin
        if (rst_left == 0 && int'($urandom_range(99)) < phases[ph].prst)
          rst_left = int'($urandom_range(3, 1));
        cycle(phases[ph].p0, phases[ph].p1, phases[ph].pwr, rst_left > 0);
        if (rst_left > 0) rst_left--;
      end
    end
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1'b0);
    @(negedge clk);
    #6;
    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors left unchecked, required 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
